// File: rtl/parity_check_stream.sv
// Streaming parity checker: registers each accepted word, regenerates its parity
// under the sampled mode, flags mismatches and keeps a saturating error count.
//
// state | meaning
// EMPTY | output stage holds no word, out_valid=0
// FULL  | output stage holds a checked word, out_valid=1
module parity_check_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              mode_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_pe,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   accept;
    logic   gen_par;
    logic   pe;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign gen_par   = (^in_data) ^ mode_odd;
    assign pe        = (in_par != gen_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (out_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_par  <= 1'b0;
            out_pe   <= 1'b0;
        end else if (accept) begin
            out_data <= in_data;
            out_par  <= gen_par;
            out_pe   <= pe;
        end
    end

    // Clear wins over a same-cycle error word; the word itself still carries out_pe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (accept && pe) begin
            err_sticky <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/parity_check_stream.md
PARITY_CHECK_STREAM -- requirements
Module: parity_check_stream

Interface
REQ-001 Parameter DATA_W, default 8: width of the data word checked per transfer; legal range 2..64.
REQ-002 Parameter CNT_W, default 16: width of the error counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  1: upstream word valid.
REQ-006 Port in_ready  output  1: block can accept a word this cycle.
REQ-007 Port in_data  input  DATA_W: data word under check.
REQ-008 Port in_par  input  1: received parity bit accompanying in_data.
REQ-009 Port mode_odd  input  1: 0 = even parity, 1 = odd parity; sampled with each accepted word.
REQ-010 Port out_valid  output  1: checked word available downstream.
REQ-011 Port out_ready  input  1: downstream accepts the word.
REQ-012 Port out_data  output  DATA_W: registered copy of the accepted in_data.
REQ-013 Port out_par  output  1: parity generated from the accepted in_data under the sampled mode.
REQ-014 Port out_pe  output  1: parity error flag for the word on out_data.
REQ-015 Port clr_err  input  1: synchronous clear of err_cnt and err_sticky.
REQ-016 Port err_cnt  output  CNT_W: count of words accepted with a parity error.
REQ-017 Port err_sticky  output  1: set on the first accepted error word; held until clr_err or reset.

Function
REQ-018 Accept: a word is accepted when in_valid && in_ready are both 1 at a rising edge.
REQ-019 in_ready = !out_valid || out_ready (combinational), so the block sustains one word per cycle when downstream is not stalled.
REQ-020 Generated parity: gen = ^in_data XOR mode_odd; for even mode, an all-zero word gives gen=0; for odd mode, it gives gen=1.
REQ-021 Error: pe = (in_par != gen); evaluated only on the accepted word, using the mode_odd value of the same cycle.
REQ-022 Latency: exactly 1 cycle; on accept, out_data, out_par and out_pe load and out_valid=1 on the following cycle.
REQ-023 Hold: while out_valid=1 && out_ready=0, out_data, out_par and out_pe remain stable, and in_ready=0.
REQ-024 Drain: out_valid=1 && out_ready=1 && no accept leads to out_valid=0 next cycle; a simultaneous accept keeps out_valid=1 with the new word.
REQ-025 State machine for the output stage: EMPTY (out_valid=0) goes to FULL on accept. FULL stays in FULL on (out_ready && accept) or !out_ready. FULL goes to EMPTY on out_ready && !accept.
REQ-026 err_cnt increments by 1 on each accepted word with pe=1; it saturates at 2^CNT_W-1 and does not wrap.
REQ-027 err_sticky goes to 1 on the first accepted word with pe=1.
REQ-028 clr_err=1 sets err_cnt to 0 and err_sticky to 0 next cycle; it takes precedence over a simultaneous error word, which is not counted.
REQ-029 clr_err does not affect the data path, out_valid or out_pe.
REQ-030 mode_odd changes between words take effect on the next accepted word only; words already on the output are unaffected.

Reset
REQ-031 When rst_n=0, the block immediately (asynchronously) forces: out_valid=0, out_data=0, out_par=0, out_pe=0, err_cnt=0, err_sticky=0.
REQ-032 While rst_n=0, in_ready=1 follows from out_valid=0, but no word is accepted.
REQ-033 Reset asserted mid-transfer discards the word held in the output stage; after release, the first edge with in_valid=1 accepts normally.

Verification
REQ-034 Even mode, in_data=8'b11101110, in_par=0 -> next cycle out_valid=1, out_par=0, out_pe=0, err_cnt unchanged.
REQ-035 Even mode, in_data=8'b11111000, in_par=0 -> out_par=1, out_pe=1, err_cnt=1, err_sticky=1; then odd mode with the same word and in_par=0 -> out_pe=0, err_cnt stays 1.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data stable; release -> one transfer per cycle, no word lost or duplicated (scoreboard of 16 random words).
REQ-037 Saturation with CNT_W=2: 5 consecutive error words -> err_cnt reads 1,2,3,3,3.
REQ-038 clr_err asserted in the same cycle as an accepted error word -> err_cnt=0 and err_sticky=0 next cycle; the word's out_pe=1 is still delivered.
REQ-039 Apply rst_n=0 asynchronously mid-cycle while out_valid=1 -> all outputs reach reset values before the next clock edge; DATA_W=32 is run with the same scenarios.
